// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN image loader.
package snn_pkg;

  localparam int IMG_PIXELS      = 784;
  localparam int BYTES_PER_FRAME = 98;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE,
    HOLD
  } loader_state_t;

endpackage

// File: rtl/loader_timer.sv
// Inter-byte timer: counts while enabled, saturates at CYC-1 and reports expiry.
module loader_timer #(
  parameter int unsigned CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (CYC > 1) ? $clog2(CYC) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_image_loader.sv
// Streams UART bytes into a 1-bit-wide image RAM, LSB first, and hands complete frames to the core.
// Optional inter-byte abort is enabled by defining LOADER_TIMEOUT_EN.
module uart_image_loader #(
  parameter int BYTES_PER_FRAME = snn_pkg::BYTES_PER_FRAME,
  parameter int ADDR_W          = 10,
  parameter int TIMEOUT_CYC     = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              core_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
);

  import snn_pkg::*;

  localparam int CNT_W = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              overrun_q, overrun_d;
  logic              drop;
  logic              timeout_evt;

`ifdef LOADER_TIMEOUT_EN
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  // The timer runs from every accepted byte; only its expiry in WAIT aborts the frame.
  assign tmr_clr = rx_rdy && !drop &&
                   ((state_q == IDLE) || (state_q == LOAD) || (state_q == WAIT));
  assign tmr_en  = (state_q == LOAD) || (state_q == WAIT);

  loader_timer #(
    .CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  assign timeout_evt = (state_q == WAIT) && tmr_expired && !rx_rdy;
`else
  assign timeout_evt = 1'b0;
`endif

  assign ram_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;
  assign timeout  = timeout_evt;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    drop       = 1'b0;
    ram_we     = 1'b0;
    ram_data   = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          shreg_d = rx_data;
          state_d = LOAD;
        end
      end

      LOAD: begin
        ram_we    = 1'b1;
        ram_data  = shreg_q[0];
        addr_d    = addr_q + 1'b1;
        shreg_d   = {1'b0, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q != 3'd7) begin
          if (rx_rdy) begin
            if (buf_full_q) begin
              drop = 1'b1;
            end else begin
              buf_d      = rx_data;
              buf_full_d = 1'b1;
            end
          end
        end else if (byte_cnt_q == CNT_W'(BYTES_PER_FRAME - 1)) begin
          // Anything still queued belongs to no frame once the image is complete.
          state_d    = DONE;
          buf_full_d = 1'b0;
          drop       = rx_rdy || buf_full_q;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (buf_full_q) begin
            shreg_d    = buf_q;
            buf_d      = rx_data;
            buf_full_d = rx_rdy;
          end else if (rx_rdy) begin
            shreg_d = rx_data;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (rx_rdy) begin
          shreg_d = rx_data;
          state_d = LOAD;
        end else if (timeout_evt) begin
          addr_d     = '0;
          byte_cnt_d = '0;
          state_d    = IDLE;
        end
      end

      DONE: begin
        frame_done = 1'b1;
        addr_d     = '0;
        byte_cnt_d = '0;
        drop       = rx_rdy;
        state_d    = HOLD;
      end

      HOLD: begin
        drop = rx_rdy;
        if (core_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q == IDLE && rx_rdy) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q | drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule
